// File: rtl/identify_unit_if.sv
// Fetch-slot / branch-unit bundle for identify_unit; o_branch_count exists only
// when IDENTIFY_BRANCH_COUNT_EN is defined.
interface identify_unit_if;
  logic        i_en;
  logic [0:63] i_instr;
  logic [0:31] o_bu_instr;
  logic        o_bu_en;
  logic        o_bu_i_form;
  logic        o_bu_b_form;
  logic        o_bu_cond_LR;
  logic        o_bu_cond_CTR;
  logic        o_bu_cond_TAR;
`ifdef IDENTIFY_BRANCH_COUNT_EN
  logic [31:0] o_branch_count;
`endif

  // Fetch side drives the slot and observes the branch-unit outputs.
  modport master (
    output i_en,
    output i_instr,
    input  o_bu_instr,
    input  o_bu_en,
    input  o_bu_i_form,
    input  o_bu_b_form,
    input  o_bu_cond_LR,
    input  o_bu_cond_CTR,
`ifdef IDENTIFY_BRANCH_COUNT_EN
    input  o_branch_count,
`endif
    input  o_bu_cond_TAR
  );

  modport slave (
    input  i_en,
    input  i_instr,
    output o_bu_instr,
    output o_bu_en,
    output o_bu_i_form,
    output o_bu_b_form,
    output o_bu_cond_LR,
    output o_bu_cond_CTR,
`ifdef IDENTIFY_BRANCH_COUNT_EN
    output o_branch_count,
`endif
    output o_bu_cond_TAR
  );
endinterface

// File: rtl/identify_unit.sv
// Combinational Power ISA branch identifier feeding the branch unit.
// Optional registered branch counter enabled by IDENTIFY_BRANCH_COUNT_EN.
module identify_unit (
  input  logic             i_clk,
  input  logic             i_rst,
  identify_unit_if.slave   bus
);

  localparam logic [5:0] PO_B      = 6'd18;
  localparam logic [5:0] PO_BC     = 6'd16;
  localparam logic [5:0] PO_XL     = 6'd19;
  localparam logic [9:0] XO_BCLR   = 10'd16;
  localparam logic [9:0] XO_BCCTR  = 10'd528;
  localparam logic [9:0] XO_BCTAR  = 10'd560;

  logic [5:0] w_po;
  logic [9:0] w_xo;
  logic       w_valid;
  logic       w_clsI;
  logic       w_clsB;
  logic       w_clsLR;
  logic       w_clsCTR;
  logic       w_clsTAR;
  logic       w_isBranch;
  logic       w_buEn;

  assign w_po    = bus.i_instr[0:5];
  assign w_xo    = bus.i_instr[21:30];
  assign w_valid = bus.i_en & ~i_rst;

  // Only PO and XO select a class, so unknown bits elsewhere cannot leak in.
  always_comb begin
    w_clsI   = 1'b0;
    w_clsB   = 1'b0;
    w_clsLR  = 1'b0;
    w_clsCTR = 1'b0;
    w_clsTAR = 1'b0;
    case (w_po)
      PO_B:  w_clsI = 1'b1;
      PO_BC: w_clsB = 1'b1;
      PO_XL: begin
        case (w_xo)
          XO_BCLR:  w_clsLR  = 1'b1;
          XO_BCCTR: w_clsCTR = 1'b1;
          XO_BCTAR: w_clsTAR = 1'b1;
          default:  ;
        endcase
      end
      default: ;
    endcase
  end

  assign w_isBranch = w_clsI | w_clsB | w_clsLR | w_clsCTR | w_clsTAR;
  assign w_buEn     = w_valid & w_isBranch;

  assign bus.o_bu_en       = w_buEn;
  assign bus.o_bu_i_form   = w_valid & w_clsI;
  assign bus.o_bu_b_form   = w_valid & w_clsB;
  assign bus.o_bu_cond_LR  = w_valid & w_clsLR;
  assign bus.o_bu_cond_CTR = w_valid & w_clsCTR;
  assign bus.o_bu_cond_TAR = w_valid & w_clsTAR;
  assign bus.o_bu_instr    = w_buEn ? bus.i_instr[0:31] : 32'h0;

`ifdef IDENTIFY_BRANCH_COUNT_EN
  logic [31:0] r_branch_count;

  // Counts accepted branches; reset wins over increment, wrap is natural.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_branch_count <= 32'h0;
    else if (w_buEn)
      r_branch_count <= r_branch_count + 32'd1;
  end

  assign bus.o_branch_count = r_branch_count;

  logic w_unused;
  assign w_unused = &{1'b0, bus.i_instr[32:63]};
`else
  logic w_unused;
  assign w_unused = &{1'b0, i_clk, bus.i_instr[32:63]};
`endif

endmodule

// File: tb/tb_identify_unit.sv
// Table-driven scoreboard bench for identify_unit; counter checks are compiled
// only when IDENTIFY_BRANCH_COUNT_EN is defined.
module tb_identify_unit;

  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_I    = 6'b110000;
  localparam logic [5:0] F_B    = 6'b101000;
  localparam logic [5:0] F_LR   = 6'b100100;
  localparam logic [5:0] F_CTR  = 6'b100010;
  localparam logic [5:0] F_TAR  = 6'b100001;

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic [0:63] instr;
    logic [0:31] expInstr;
    logic [5:0]  expFlags;
  } vec_t;

  typedef struct {
    string       name;
    logic [0:31] expInstr;
    logic [5:0]  expFlags;
  } exp_t;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;
  exp_t sbQueue[$];
  vec_t vecs[$];

  identify_unit_if bus();

  identify_unit dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input string name, input logic r, input logic e,
                               input logic [0:63] instr, input logic [0:31] expInstr,
                               input logic [5:0] expFlags);
    exp_t x;
    rst         = r;
    bus.i_en    = e;
    bus.i_instr = instr;
    x.name      = name;
    x.expInstr  = expInstr;
    x.expFlags  = expFlags;
    sbQueue.push_back(x);
  endtask

  task automatic checkOutput();
    exp_t        x;
    logic [5:0]  actFlags;
    logic [0:31] actInstr;
    checkCount++;
    if (sbQueue.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty: no expectation queued");
      return;
    end
    x = sbQueue.pop_front();
    actFlags = {bus.o_bu_en, bus.o_bu_i_form, bus.o_bu_b_form,
                bus.o_bu_cond_LR, bus.o_bu_cond_CTR, bus.o_bu_cond_TAR};
    actInstr = bus.o_bu_instr;
    if (actInstr === x.expInstr) passCount++;
    else $display("[TB] FAIL %s_instr: got %h expected %h", x.name, actInstr, x.expInstr);
    checkCount++;
    if (actFlags === x.expFlags) passCount++;
    else $display("[TB] FAIL %s_flags: got %b expected %b", x.name, actFlags, x.expFlags);
  endtask

`ifdef IDENTIFY_BRANCH_COUNT_EN
  task automatic checkCountValue(input string name, input logic [31:0] exp);
    checkCount++;
    if (bus.o_branch_count === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, bus.o_branch_count, exp);
  endtask
`endif

  initial begin
    checkCount  = 0;
    passCount   = 0;
    rst         = 1'b1;
    bus.i_en    = 1'b0;
    bus.i_instr = 64'h0;

    vecs.push_back('{"b_bl",        1'b0, 1'b1, {32'h48032BFB, 32'h0},        32'h48032BFB, F_I});
    vecs.push_back('{"beq",         1'b0, 1'b1, {32'h41820010, 32'h0},        32'h41820010, F_B});
    vecs.push_back('{"blr",         1'b0, 1'b1, {32'h4E800020, 32'h0},        32'h4E800020, F_LR});
    vecs.push_back('{"bctr",        1'b0, 1'b1, {32'h4E800420, 32'h0},        32'h4E800420, F_CTR});
    vecs.push_back('{"bctar",       1'b0, 1'b1, {32'h4E800460, 32'h0},        32'h4E800460, F_TAR});
    vecs.push_back('{"blrl",        1'b0, 1'b1, {32'h4E800021, 32'h0},        32'h4E800021, F_LR});
    vecs.push_back('{"bla",         1'b0, 1'b1, {32'h48000003, 32'h0},        32'h48000003, F_I});
    vecs.push_back('{"bc_xo_bits",  1'b0, 1'b1, {32'h40000420, 32'h0},        32'h40000420, F_B});
    vecs.push_back('{"b_suffix",    1'b0, 1'b1, {32'h48000000, 32'hFFFFFFFF}, 32'h48000000, F_I});
    vecs.push_back('{"isync",       1'b0, 1'b1, {32'h4C00012C, 32'h0},        32'h0,        F_NONE});
    vecs.push_back('{"mcrf",        1'b0, 1'b1, {32'h4C000000, 32'h0},        32'h0,        F_NONE});
    vecs.push_back('{"li",          1'b0, 1'b1, {32'h38600001, 32'h0},        32'h0,        F_NONE});
    vecs.push_back('{"po31_xo16",   1'b0, 1'b1, {32'h7C000020, 32'h0},        32'h0,        F_NONE});
    vecs.push_back('{"prefixed",    1'b0, 1'b1, {32'h06000000, 32'h48000000}, 32'h0,        F_NONE});
    vecs.push_back('{"blr_en0",     1'b0, 1'b0, {32'h4E800020, 32'h0},        32'h0,        F_NONE});
    vecs.push_back('{"blr_rst",     1'b1, 1'b1, {32'h4E800020, 32'h0},        32'h0,        F_NONE});

    $display("[TB] reset phase");
    @(negedge clk);
    applyStimulus("reset", 1'b1, 1'b0, {32'h4E800020, 32'h0}, 32'h0, F_NONE);
    @(posedge clk);
    #1 checkOutput();

    // Deassert reset off-edge and expect decode to appear with no clock edge.
    @(negedge clk);
    applyStimulus("rst_release", 1'b0, 1'b1, {32'h48032BFB, 32'h0}, 32'h48032BFB, F_I);
    #1 checkOutput();

    $display("[TB] table phase");
    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i].name, vecs[i].rst, vecs[i].en, vecs[i].instr,
                    vecs[i].expInstr, vecs[i].expFlags);
      #1 checkOutput();
    end

    $display("[TB] enable toggle phase");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k % 2 == 0)
        applyStimulus("toggle_on", 1'b0, 1'b1, {32'h4E800460, 32'h0}, 32'h4E800460, F_TAR);
      else
        applyStimulus("toggle_off", 1'b0, 1'b0, {32'h4E800460, 32'h0}, 32'h0, F_NONE);
      #1 checkOutput();
    end

    // Reset pulse mid-cycle with a branch present, then release mid-cycle.
    @(negedge clk);
    applyStimulus("rst_mid_on", 1'b1, 1'b1, {32'h4E800420, 32'h0}, 32'h0, F_NONE);
    #1 checkOutput();
    #1;
    applyStimulus("rst_mid_off", 1'b0, 1'b1, {32'h4E800420, 32'h0}, 32'h4E800420, F_CTR);
    #1 checkOutput();

`ifdef IDENTIFY_BRANCH_COUNT_EN
    $display("[TB] counter phase");
    @(negedge clk);
    rst = 1'b1; bus.i_en = 1'b0;
    @(posedge clk);
    #1 checkCountValue("count_reset", 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.i_en = 1'b1;
      bus.i_instr = (k == 1 || k == 3) ? {32'h38600001, 32'h0} : {32'h41820010, 32'h0};
      @(posedge clk);
    end
    #1 checkCountValue("count_three", 32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 checkCountValue("count_after_rst", 32'd0);
    @(negedge clk);
    rst = 1'b0; bus.i_en = 1'b0;
    force dut.r_branch_count = 32'hFFFFFFFF;
    #1 release dut.r_branch_count;
    bus.i_en = 1'b1; bus.i_instr = {32'h4E800020, 32'h0};
    @(posedge clk);
    #1 checkCountValue("count_wrap", 32'd0);
    @(negedge clk);
    bus.i_en = 1'b0;
    @(posedge clk);
    #1 checkCountValue("count_hold", 32'd0);
`endif

    if (sbQueue.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sbQueue.size());
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/identify_unit.md
Name: identify_unit

Overview:
- Front-end decode stage for the Power ISA core.
- Inspects one fetched instruction slot (up to 64 bits, word 0 in bits 0:31) and classifies branches.
- Forwards branch instructions to the branch unit (BU) with a one-hot form/target qualifier.
- Decode path is purely combinational (same-cycle). Only the optional statistics counter is registered.

Parameters:
- None. Widths are fixed by the ISA.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_en  input  1  slot valid; when 0 all BU outputs are 0.
- i_instr  input  [0:63]  instruction slot, big-endian bit numbering; bits 0:31 = word 0, bits 32:63 = suffix word (prefixed only).
- o_bu_instr  output  [0:31]  instruction word handed to the BU.
- o_bu_en  output  1  BU enable: the word is a recognised branch.
- o_bu_i_form  output  1  I-form branch (b/ba/bl/bla).
- o_bu_b_form  output  1  B-form conditional branch (bc*).
- o_bu_cond_LR  output  1  XL-form branch-conditional to LR (bclr*).
- o_bu_cond_CTR  output  1  XL-form branch-conditional to CTR (bcctr*).
- o_bu_cond_TAR  output  1  XL-form branch-conditional to TAR (bctar*).

Behaviour:
- Fields:
  - PO = i_instr[0:5].
  - XO = i_instr[21:30].
  - LK (bit 31) and AA (bit 30 for I/B-form) do not affect classification.
- Classification, with valid = i_en & ~i_rst:
  - PO=18 (0b010010) -> i_form.
  - PO=16 (0b010000) -> b_form.
  - PO=19 (0b010011):
    - XO=16 -> cond_LR.
    - XO=528 -> cond_CTR.
    - XO=560 -> cond_TAR.
    - Any other XO (mcrf, isync, cr ops, rfid, ...) is not a branch.
  - PO=1 (prefix): never a branch; the whole 64-bit slot is ignored by this block.
  - All other PO: not a branch.
- Output rules:
  - o_bu_en = valid & (any of the five classes).
  - Each form flag = valid & its class.
  - When o_bu_en=1, exactly one form flag is 1. When o_bu_en=0, all flags are 0.
  - o_bu_instr = i_instr[0:31] when o_bu_en=1, else 32'h0.
  - i_instr[32:63] never reaches any output.
- Latency and handshake:
  - Zero cycles: outputs settle combinationally within the same cycle as i_instr/i_en change.
  - No handshake or backpressure. The downstream BU samples on its own clock edge.
- Reset:
  - While i_rst=1, all outputs are forced to 0 combinationally.
  - Registered state (optional counter) clears on the rising edge of i_clk with i_rst=1.
  - Deasserting i_rst mid-cycle makes decode valid immediately, with no clock edge required.
- Boundary conditions:
  - i_en toggling with stable i_instr: outputs follow i_en with no memory.
  - X/Z on i_instr bits outside PO/XO must not alter classification.

Optional Feature:
- Macro IDENTIFY_BRANCH_COUNT_EN.
- Defined:
  - Adds output o_branch_count [31:0].
  - Increments by 1 on each rising edge of i_clk where o_bu_en=1.
  - Wraps 32'hFFFFFFFF -> 0.
  - Synchronous reset to 0; i_rst has priority over increment.
  - Holds when o_bu_en=0.
- Undefined:
  - The port and the register do not exist.
  - Decode behaviour is identical in both builds.

Test Plan:
- Reset then enable: i_rst=1,i_en=0 for 1 clk -> all outputs 0. Then i_rst=0,i_en=1, i_instr={32'h48032BFB,32'h0}, check after 1 time unit with no clock edge -> o_bu_instr=32'h48032BFB, o_bu_en=1, o_bu_i_form=1, other flags 0.
- B-form: word0=32'h41820010 (beq +16) -> o_bu_en=1, o_bu_b_form=1, others 0, o_bu_instr=32'h41820010.
- XL-form targets:
  - 32'h4E800020 (blr) -> o_bu_cond_LR=1.
  - 32'h4E800420 (bctr) -> o_bu_cond_CTR=1.
  - 32'h4E800460 (bctar) -> o_bu_cond_TAR=1.
  - Each case: o_bu_en=1, remaining flags 0.
- Non-branches:
  - 32'h4C00012C (isync, PO=19 XO=150) -> all outputs 0.
  - 32'h38600001 (li r3,1) -> all outputs 0.
  - Prefixed slot {32'h06000000,32'h48000000} -> all outputs 0 (suffix word ignored).
- Gating: blr word with i_en=0 -> all 0. Same word with i_en=1, i_rst=1 -> all 0.
- With IDENTIFY_BRANCH_COUNT_EN:
  - 3 branch cycles, 2 non-branch cycles -> o_branch_count=3.
  - Assert i_rst for 1 clk -> 0.
  - Preload by running to 32'hFFFFFFFF, one more branch -> 0.
